// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops emulating TTL 7476/74112 behaviour
// inside a single system clock domain, with a per-channel change strobe.
module jk_ff_bank #(
   parameter int WIDTH   = 2,
   parameter int MODE    = 0,
   parameter int RESET_Q = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cp,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] pre_n,
   input  logic [WIDTH-1:0] clr_n,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] q_chg
);

   localparam logic RST_BIT = (RESET_Q != 0);

   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] cp_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] qn_next;
   logic [WIDTH-1:0] m_next;

   assign rise = cp & ~cp_d;
   assign fall = ~cp & cp_d;

   // Asynchronous-style preset/clear levels win over any clock action; with both
   // low the outputs sit in the TTL both-high state until released.
   always_comb begin
      q_next  = q;
      qn_next = q_n;
      m_next  = m;
      for (int i = 0; i < WIDTH; i++) begin
         if (!pre_n[i] || !clr_n[i]) begin
            q_next[i]  = ~pre_n[i];
            qn_next[i] = ~clr_n[i];
            m_next[i]  = ~pre_n[i];
         end else begin
            qn_next[i] = ~q[i];
            if (MODE == 0) begin
               if (rise[i]) begin
                  m_next[i] = q[i];
               end
               // Ones catching: J is only heard while q=0 and K while q=1, so
               // once the master departs from q nothing can pull it back.
               if (cp[i]) begin
                  if (!q[i] && j[i]) begin
                     m_next[i] = 1'b1;
                  end else if (q[i] && k[i]) begin
                     m_next[i] = 1'b0;
                  end
               end
               if (fall[i]) begin
                  q_next[i]  = m[i];
                  qn_next[i] = ~m[i];
               end
            end else begin
               if (fall[i]) begin
                  case ({j[i], k[i]})
                     2'b01:   q_next[i] = 1'b0;
                     2'b10:   q_next[i] = 1'b1;
                     2'b11:   q_next[i] = ~q[i];
                     default: q_next[i] = q[i];
                  endcase
                  qn_next[i] = ~q_next[i];
               end
               m_next[i] = q_next[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= {WIDTH{RST_BIT}};
         q_n   <= {WIDTH{~RST_BIT}};
         m     <= {WIDTH{RST_BIT}};
         cp_d  <= '0;
         q_chg <= '0;
      end else begin
         q     <= q_next;
         q_n   <= qn_next;
         m     <= m_next;
         cp_d  <= cp;
         q_chg <= q_next ^ q;
      end
   end

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: one MODE 0 and one MODE 1 instance share the
// same stimulus and are compared every cycle against a pulse-level model.
module tb_jk_ff_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cp, j, k, pre_n, clr_n;
   logic [1:0] q0, qn0, chg0, q1, qn1, chg1;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] mq     [2];
   logic [1:0] mqn    [2];
   logic [1:0] mchg   [2];
   logic [1:0] caught [2];
   logic [1:0] cp_prev;

   always #5 clk = ~clk;

   jk_ff_bank #(.WIDTH(2), .MODE(0), .RESET_Q(0)) dut0 (
      .clk(clk), .rst(rst), .cp(cp), .j(j), .k(k), .pre_n(pre_n), .clr_n(clr_n),
      .q(q0), .q_n(qn0), .q_chg(chg0)
   );

   jk_ff_bank #(.WIDTH(2), .MODE(1), .RESET_Q(0)) dut1 (
      .clk(clk), .rst(rst), .cp(cp), .j(j), .k(k), .pre_n(pre_n), .clr_n(clr_n),
      .q(q1), .q_n(qn1), .q_chg(chg1)
   );

   task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst_v, input logic [1:0] cp_v, input logic [1:0] j_v,
                                input logic [1:0] k_v, input logic [1:0] pre_v,
                                input logic [1:0] clr_v, input int cycles);
      rst   = rst_v;
      cp    = cp_v;
      j     = j_v;
      k     = k_v;
      pre_n = pre_v;
      clr_n = clr_v;
      repeat (cycles) @(negedge clk);
   endtask

   // Model thinks per pulse: in mode 0 a pulse toggles q if the gated input
   // that opposes q was seen high at any point of the high phase.
   always begin
      @(posedge clk);
      for (int md = 0; md < 2; md++) begin
         for (int i = 0; i < 2; i++) begin
            logic nq, nqn;
            logic is_rise, is_fall;
            is_rise = cp[i] && !cp_prev[i];
            is_fall = !cp[i] && cp_prev[i];
            if (rst) begin
               nq = 1'b0;
               nqn = 1'b1;
               caught[md][i] = 1'b0;
               mchg[md][i] = 1'b0;
            end else begin
               nq = mq[md][i];
               nqn = !mq[md][i];
               if (!pre_n[i] || !clr_n[i]) begin
                  nq = !pre_n[i];
                  nqn = !clr_n[i];
                  caught[md][i] = 1'b0;
               end else if (md == 0) begin
                  if (is_rise) caught[md][i] = 1'b0;
                  if (cp[i] && (mq[md][i] ? k[i] : j[i])) caught[md][i] = 1'b1;
                  if (is_fall && caught[md][i]) begin
                     nq = !mq[md][i];
                     nqn = mq[md][i];
                  end
               end else if (is_fall) begin
                  if (j[i] && k[i]) nq = !mq[md][i];
                  else if (j[i]) nq = 1'b1;
                  else if (k[i]) nq = 1'b0;
                  nqn = !nq;
               end
               mchg[md][i] = nq ^ mq[md][i];
            end
            mq[md][i] = nq;
            mqn[md][i] = nqn;
         end
      end
      cp_prev = rst ? 2'b00 : cp;
      #1;
      checkOutput("mode0 q", q0, mq[0]);
      checkOutput("mode0 q_n", qn0, mqn[0]);
      checkOutput("mode0 q_chg", chg0, mchg[0]);
      checkOutput("mode1 q", q1, mq[1]);
      checkOutput("mode1 q_n", qn1, mqn[1]);
      checkOutput("mode1 q_chg", chg1, mchg[1]);
   end

   initial begin
      cp_prev = 2'b00;
      // Reset, then preset channel 0 for one cycle
      applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2);
      checkOutput("reset q", q0, 2'b00);
      checkOutput("reset q_n", qn0, 2'b11);
      checkOutput("reset q_chg", chg0, 2'b00);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 1);
      checkOutput("preset q", q0, 2'b01);
      checkOutput("preset q_chg", chg0, 2'b01);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      checkOutput("preset chg one cycle", chg0, 2'b00);

      // Both-low preset/clear on channel 1, then release
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1);
      checkOutput("both low q", q0, 2'b11);
      checkOutput("both low q_n", qn0, 2'b10);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      checkOutput("release q", q0, 2'b11);
      checkOutput("release q_n", qn0, 2'b00);

      // K-only, J=K and idle pulses on channel 0
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b01, 2'b11, 2'b11, 3);
      checkOutput("k pulse before fall", q0, 2'b11);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 1);
      checkOutput("k pulse q", q0, 2'b10);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 3);
      applyStimulus(1'b0, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 1);
      checkOutput("toggle pulse q", q0, 2'b11);
      checkOutput("toggle pulse mode1", q1, 2'b11);
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 3);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      checkOutput("hold pulse q", q0, 2'b11);

      // Ones catching: J high only on the second cycle of a 6-cycle pulse
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 1);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 4);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      checkOutput("ones catch mode0", q0, 2'b11);
      checkOutput("ones catch mode1", q1, 2'b10);

      // Clear in the middle of a pulse reloads the master
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 1);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 1);
      checkOutput("mid-pulse clear q", q0, 2'b10);
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
      checkOutput("after mid-pulse clear q", q0, 2'b10);

      // Reset while channel 1 is mid-pulse with J=K=1
      applyStimulus(1'b0, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 1);
      applyStimulus(1'b1, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 1);
      checkOutput("mid-pulse reset q", q0, 2'b00);
      checkOutput("mid-pulse reset q_chg", chg0, 2'b00);
      applyStimulus(1'b0, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 1);
      checkOutput("post reset q", q0, 2'b00);
      checkOutput("post reset q_chg", chg0, 2'b00);
      applyStimulus(1'b0, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2);
      applyStimulus(1'b0, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 1);
      checkOutput("post reset toggle q", q0, 2'b10);
      checkOutput("post reset toggle q_chg", chg0, 2'b10);
      checkOutput("post reset toggle mode1", q1, 2'b10);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2);
      checkOutput("single toggle q", q0, 2'b10);
      checkOutput("single toggle q_chg", chg0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
